// File: rtl/cm_rs_defs.sv
// Shared definitions for the cm_rs register-slice family: VR mode encodings
// and a constant-foldable ceiling-log2 helper.
package cm_rs_defs;

  typedef enum logic [1:0] {
    VR_BYP = 2'd0,
    VR_FWD = 2'd1,
    VR_BWD = 2'd2,
    VR_FUL = 2'd3
  } vr_mode_e;

  // Ceiling log2; clog2(1) == 0, clog2(5) == 3.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage : cm_rs_defs

// File: rtl/cm_rs_vr_chain_if.sv
// Valid/ready/payload handshake bundle. The master drives vld/pld, the slave
// drives rdy.
interface cm_rs_vr_chain_if #(
  parameter int PLD_WIDTH = 8
);
  logic                 vld;
  logic                 rdy;
  logic [PLD_WIDTH-1:0] pld;

  modport master (output vld, output pld, input rdy);
  modport slave  (input vld, input pld, output rdy);
endinterface : cm_rs_vr_chain_if

// File: rtl/cm_rs_vr_chain_mem.sv
// Circular store of ENTRIES payload words behind the output register of
// cm_rs_vr_chain. Pointers wrap at ENTRIES-1, any ENTRIES >= 1.
module cm_rs_vr_chain_mem
  import cm_rs_defs::*;
#(
  parameter int PLD_WIDTH = 8,
  parameter int ENTRIES   = 1,
  parameter bit NO_RST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [PLD_WIDTH-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [PLD_WIDTH-1:0] o_rd_data
);

  localparam int PTR_W = (ENTRIES > 1) ? clog2(ENTRIES) : 1;
  // A single-entry store still gets a 1-bit pointer, so give it two slots to
  // keep the array index width consistent; the second slot is never addressed.
  localparam int SLOTS = (ENTRIES > 1) ? ENTRIES : 2;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(ENTRIES - 1);

  logic [PLD_WIDTH-1:0] r_mem [SLOTS];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // NOTE: storage is cleared only when NO_RST=0; otherwise it stays a plain
  // register array with no reset fan-out, and validity comes from the level.
  always_ff @(posedge clk) begin
    if (rst && !NO_RST) begin
      for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];

endmodule : cm_rs_vr_chain_mem

// File: rtl/cm_rs_vr_chain.sv
// Elastic DEPTH-entry valid/ready buffer with fully registered outputs,
// occupancy and flush. Optional stall counter: CM_RS_VR_CHAIN_STALL_CNT_EN.
module cm_rs_vr_chain
  import cm_rs_defs::*;
#(
  parameter  int PLD_WIDTH = 8,
  parameter  int DEPTH     = 2,
  parameter  bit NO_RST    = 1'b1,
  localparam int LVL_W     = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  cm_rs_vr_chain_if.slave   src,
  cm_rs_vr_chain_if.master  dst,
  output logic [LVL_W-1:0]  lvl,
  output logic              full
`ifdef CM_RS_VR_CHAIN_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

  logic [LVL_W-1:0]     r_lvl;
  logic                 r_dst_vld;
  logic                 r_src_rdy;
  logic [PLD_WIDTH-1:0] r_dst_pld;

  logic                 w_push;
  logic                 w_pop;
  logic [LVL_W-1:0]     w_lvl_next;
  logic                 w_load_src;
  logic                 w_mem_wr;
  logic                 w_mem_rd;
  logic [PLD_WIDTH-1:0] w_mem_data;

  // The output register always holds the oldest entry; the store holds the
  // rest. A word goes straight to the output register only when it would
  // otherwise be the oldest entry after this edge.
  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_push     = src.vld & r_src_rdy;
    w_pop      = r_dst_vld & dst.rdy;
    w_lvl_next = r_lvl;
    w_load_src = 1'b0;
    w_mem_wr   = 1'b0;
    w_mem_rd   = 1'b0;
    if (!flush) begin
      w_lvl_next = r_lvl + LVL_W'(w_push) - LVL_W'(w_pop);
      case ({w_push, w_pop})
        2'b10: begin
          w_load_src = (r_lvl == '0);
          w_mem_wr   = (r_lvl != '0);
        end
        2'b01: begin
          w_mem_rd   = (r_lvl > ONE_L);
        end
        2'b11: begin
          w_load_src = (r_lvl == ONE_L);
          w_mem_rd   = (r_lvl > ONE_L);
          w_mem_wr   = (r_lvl > ONE_L);
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl     <= '0;
      r_dst_vld <= 1'b0;
      r_src_rdy <= 1'b0;
    end else if (flush) begin
      r_lvl     <= '0;
      r_dst_vld <= 1'b0;
      r_src_rdy <= 1'b1;
    end else begin
      r_lvl     <= w_lvl_next;
      r_dst_vld <= (w_lvl_next != '0);
      r_src_rdy <= (w_lvl_next < DEPTH_L);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !NO_RST) begin
      r_dst_pld <= '0;
    end else if (w_load_src) begin
      r_dst_pld <= src.pld;
    end else if (w_mem_rd) begin
      r_dst_pld <= w_mem_data;
    end
  end

  cm_rs_vr_chain_mem #(
    .PLD_WIDTH (PLD_WIDTH),
    .ENTRIES   (DEPTH - 1),
    .NO_RST    (NO_RST)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (flush),
    .i_wr_en   (w_mem_wr),
    .i_wr_data (src.pld),
    .i_rd_en   (w_mem_rd),
    .o_rd_data (w_mem_data)
  );

`ifdef CM_RS_VR_CHAIN_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_stall_cnt <= '0;
    end else if (r_dst_vld && !dst.rdy && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign src.rdy = r_src_rdy;
  assign dst.vld = r_dst_vld;
  assign dst.pld = r_dst_pld;
  assign lvl     = r_lvl;
  assign full    = (r_lvl == DEPTH_L);

endmodule : cm_rs_vr_chain

// File: tb/tb_cm_rs_vr_chain.sv
// Directed bench for cm_rs_vr_chain: a DEPTH=3 (payload reset) instance and a
// DEPTH=5 (no payload reset) instance, each tracked by a scoreboard queue.
module tb_cm_rs_vr_chain;

  localparam int W  = 8;
  localparam int DA = 3;
  localparam int DB = 5;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cm_rs_vr_chain_if #(.PLD_WIDTH(W)) a_src ();
  cm_rs_vr_chain_if #(.PLD_WIDTH(W)) a_dst ();
  cm_rs_vr_chain_if #(.PLD_WIDTH(W)) b_src ();
  cm_rs_vr_chain_if #(.PLD_WIDTH(W)) b_dst ();

  logic [1:0] lvl_a;
  logic [2:0] lvl_b;
  logic       full_a;
  logic       full_b;
`ifdef CM_RS_VR_CHAIN_STALL_CNT_EN
  logic [15:0] stall_a;
  logic [15:0] stall_b;
`endif

  cm_rs_vr_chain #(.PLD_WIDTH(W), .DEPTH(DA), .NO_RST(1'b0)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src       (a_src),
    .dst       (a_dst),
    .lvl       (lvl_a),
    .full      (full_a)
`ifdef CM_RS_VR_CHAIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_a)
`endif
  );

  cm_rs_vr_chain #(.PLD_WIDTH(W), .DEPTH(DB), .NO_RST(1'b1)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src       (b_src),
    .dst       (b_dst),
    .lvl       (lvl_b),
    .full      (full_b)
`ifdef CM_RS_VR_CHAIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q_a [$];
  logic [W-1:0] q_b [$];
  int m_lvl_a = 0, m_lvl_b = 0;
  bit m_rdy_a = 1'b0, m_rdy_b = 1'b0;
  int n_pop_a = 0, n_pop_b = 0;
  int max_a = 0, max_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes seen before the edge, advance the model,
  // then compare the registered outputs just after the edge.
  task automatic tick();
    bit pa, oa, pb, ob;
    pa = a_src.vld && a_src.rdy;
    oa = a_dst.vld && a_dst.rdy;
    pb = b_src.vld && b_src.rdy;
    ob = b_dst.vld && b_dst.rdy;
    if (!rst && !flush) begin
      if (oa) begin
        n_pop_a++;
        if (q_a.size() == 0) check("a_pop_unexpected", 1, 0);
        else check("a_order", a_dst.pld, q_a.pop_front());
      end
      if (pa) q_a.push_back(a_src.pld);
      if (ob) begin
        n_pop_b++;
        if (q_b.size() == 0) check("b_pop_unexpected", 1, 0);
        else check("b_order", b_dst.pld, q_b.pop_front());
      end
      if (pb) q_b.push_back(b_src.pld);
      m_lvl_a = m_lvl_a + int'(pa) - int'(oa);
      m_lvl_b = m_lvl_b + int'(pb) - int'(ob);
      m_rdy_a = (m_lvl_a < DA);
      m_rdy_b = (m_lvl_b < DB);
    end else begin
      q_a.delete();
      q_b.delete();
      m_lvl_a = 0;
      m_lvl_b = 0;
      m_rdy_a = !rst;
      m_rdy_b = !rst;
    end
    @(posedge clk);
    #1;
    if (int'(lvl_a) > max_a) max_a = int'(lvl_a);
    if (int'(lvl_b) > max_b) max_b = int'(lvl_b);
    check("a_lvl",  lvl_a,     m_lvl_a);
    check("a_vld",  a_dst.vld, m_lvl_a != 0);
    check("a_full", full_a,    m_lvl_a == DA);
    check("a_rdy",  a_src.rdy, m_rdy_a);
    check("b_lvl",  lvl_b,     m_lvl_b);
    check("b_vld",  b_dst.vld, m_lvl_b != 0);
    check("b_full", full_b,    m_lvl_b == DB);
    check("b_rdy",  b_src.rdy, m_rdy_b);
  endtask

  initial begin
    int cyc;
    int pops0;
    int idx;
    bit acc;

    a_src.vld = 1'b0; a_src.pld = '0; a_dst.rdy = 1'b0;
    b_src.vld = 1'b0; b_src.pld = '0; b_dst.rdy = 1'b0;

    // Reset held for three cycles, then released.
    repeat (3) tick();
    check("rst_a_rdy", a_src.rdy, 0);
    check("rst_a_vld", a_dst.vld, 0);
    check("rst_a_lvl", lvl_a, 0);
    check("rst_a_pld", a_dst.pld, 0);
    check("rst_b_rdy", b_src.rdy, 0);
    rst = 1'b0;
    tick();
    check("rel_a_rdy", a_src.rdy, 1);
    check("rel_b_rdy", b_src.rdy, 1);

    // Streaming 0x01..0x20 with downstream always ready.
    a_dst.rdy = 1'b1;
    max_a = 0;
    pops0 = n_pop_a;
    cyc = 0;
    idx = 1;
    while (idx <= 32 && cyc < 100) begin
      a_src.vld = 1'b1;
      a_src.pld = W'(idx);
      acc = a_src.rdy;
      tick();
      cyc++;
      if (cyc == 1) begin
        check("stream_first_vld", a_dst.vld, 1);
        check("stream_first_pld", a_dst.pld, 8'h01);
      end
      if (acc) idx++;
    end
    a_src.vld = 1'b0;
    check("stream_cycles", cyc, 32);
    repeat (3) tick();
    check("stream_pops", n_pop_a - pops0, 32);
    check("stream_max_lvl", max_a <= 1, 1);
    check("stream_sb_empty", q_a.size(), 0);

    // Fill to DEPTH with downstream stalled, then drain with a pending word.
    a_dst.rdy = 1'b0;
    pops0 = n_pop_a;
    for (int k = 0; k < 3; k++) begin
      a_src.vld = 1'b1;
      a_src.pld = 8'hA0 + W'(k);
      tick();
    end
    check("fill_lvl",  lvl_a, 3);
    check("fill_full", full_a, 1);
    check("fill_rdy",  a_src.rdy, 0);
    a_src.pld = 8'hA3;
    repeat (2) tick();
    check("fill_hold_pld", a_dst.pld, 8'hA0);
    check("fill_hold_lvl", lvl_a, 3);
    a_dst.rdy = 1'b1;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 20) begin
      acc = a_src.rdy;
      tick();
      cyc++;
    end
    check("fill_a3_taken", acc, 1);
    a_src.vld = 1'b0;
    repeat (5) tick();
    check("drain_pops", n_pop_a - pops0, 4);
    check("drain_sb_empty", q_a.size(), 0);

    // Reset in the middle of a burst drops the held words.
    a_dst.rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_src.vld = 1'b1;
      a_src.pld = 8'hD0 + W'(k);
      tick();
    end
    a_src.vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_lvl", lvl_a, 0);
    check("midrst_pld", a_dst.pld, 0);
    tick();
    check("midrst_rel_rdy", a_src.rdy, 1);

    // Flush at lvl=2 with a push and a pop offered on the same edge.
    for (int k = 0; k < 2; k++) begin
      a_src.vld = 1'b1;
      a_src.pld = 8'hB0 + W'(k);
      tick();
    end
    check("flush_pre_lvl", lvl_a, 2);
    flush = 1'b1;
    a_src.pld = 8'hB2;
    a_dst.rdy = 1'b1;
    tick();
    flush = 1'b0;
    a_src.vld = 1'b0;
    check("flush_lvl", lvl_a, 0);
    check("flush_vld", a_dst.vld, 0);
    check("flush_rdy", a_src.rdy, 1);
    pops0 = n_pop_a;
    a_src.vld = 1'b1;
    a_src.pld = 8'hC0;
    tick();
    a_src.vld = 1'b0;
    check("post_flush_pld", a_dst.pld, 8'hC0);
    repeat (2) tick();
    check("post_flush_pops", n_pop_a - pops0, 1);

    // DEPTH=5: 200 pushes against a randomly stalling sink.
    a_dst.rdy = 1'b0;
    max_b = 0;
    pops0 = n_pop_b;
    cyc = 0;
    idx = 0;
    while (idx < 200 && cyc < 2000) begin
      b_src.vld = 1'b1;
      b_src.pld = W'($urandom_range(0, 255));
      b_dst.rdy = 1'($urandom_range(0, 1));
      acc = b_src.rdy;
      tick();
      cyc++;
      if (acc) idx++;
    end
    b_src.vld = 1'b0;
    check("wrap_pushes", idx, 200);
    b_dst.rdy = 1'b1;
    repeat (8) tick();
    check("wrap_pops", n_pop_b - pops0, 200);
    check("wrap_max_lvl", max_b <= 5, 1);
    check("wrap_sb_empty", q_b.size(), 0);
    b_dst.rdy = 1'b0;

`ifdef CM_RS_VR_CHAIN_STALL_CNT_EN
    // Stall counter: count, saturate, clear on flush.
    a_dst.rdy = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_clr0", stall_a, 0);
    a_src.vld = 1'b1;
    a_src.pld = 8'hE0;
    tick();
    a_src.vld = 1'b0;
    repeat (10) tick();
    check("stall_ten", stall_a, 10);
    repeat (70000) @(posedge clk);
    #1;
    check("stall_sat", stall_a, 16'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_flush", stall_a, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cm_rs_vr_chain
